// File: rtl/lio_pkg.sv
// -----------------------------------------------------------------------------
// lio_pkg
// Shared definitions for the AXI4-Lite to local-IO (LIO) bridge:
//   - lio_br_state_e : bridge transaction state
//   - AXI_RESP_*     : AXI response codes driven on bresp/rresp
//   - lio_resp()     : maps the LIO error flag onto an AXI response code
// -----------------------------------------------------------------------------
package lio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_COLLECT,
    LIO_WR,
    WR_RESP,
    LIO_RD,
    RD_RESP
  } lio_br_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  function automatic logic [1:0] lio_resp(input logic err);
    return err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/axil_lio_bridge.sv
// -----------------------------------------------------------------------------
// axil_lio_bridge
// AXI4-Lite slave to LIO register-bus bridge. Each AXI read or write becomes
// exactly one LIO req/ack transfer; one transaction is in flight at a time.
//
// Ports
//   aclk, aresetn            clock, asynchronous active-low reset
//   aw*/w*/b*                AXI4-Lite write address / data / response
//   ar*/r*                   AXI4-Lite read address / data
//   lio_req/lio_we           LIO request (held until lio_ack), 1 = write
//   lio_addr/wdata/wstrb     LIO request payload, stable while lio_req = 1
//   lio_ack/rdata/err        LIO completion pulse with read data and error
//
// Configuration
//   AXIL_LIO_TIMEOUT_EN      when defined, a transfer without lio_ack for
//                            TIMEOUT_CYCLES cycles completes with SLVERR and
//                            read data 0; otherwise the bridge waits forever.
// -----------------------------------------------------------------------------
module axil_lio_bridge
  import lio_pkg::*;
#(
  parameter int A_WIDTH        = 32,
  parameter int D_WIDTH        = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [A_WIDTH-1:0]   awaddr,
  input  logic [2:0]           awprot,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [D_WIDTH-1:0]   wdata,
  input  logic [D_WIDTH/8-1:0] wstrb,
  input  logic                 wvalid,
  output logic                 wready,
  output logic [1:0]           bresp,
  output logic                 bvalid,
  input  logic                 bready,
  input  logic [A_WIDTH-1:0]   araddr,
  input  logic [2:0]           arprot,
  input  logic                 arvalid,
  output logic                 arready,
  output logic [D_WIDTH-1:0]   rdata,
  output logic [1:0]           rresp,
  output logic                 rvalid,
  input  logic                 rready,
  output logic                 lio_req,
  output logic                 lio_we,
  output logic [A_WIDTH-1:0]   lio_addr,
  output logic [D_WIDTH-1:0]   lio_wdata,
  output logic [D_WIDTH/8-1:0] lio_wstrb,
  input  logic                 lio_ack,
  input  logic [D_WIDTH-1:0]   lio_rdata,
  input  logic                 lio_err
);

  localparam int S_WIDTH = D_WIDTH / 8;

  lio_br_state_e      state_q, state_d;
  logic               active_q;
  logic               last_was_wr_q, last_was_wr_d;
  logic               aw_have_q, aw_have_d;
  logic               w_have_q, w_have_d;
  logic [A_WIDTH-1:0] addr_q, addr_d;
  logic [D_WIDTH-1:0] wdata_q, wdata_d;
  logic [S_WIDTH-1:0] wstrb_q, wstrb_d;
  logic [D_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]         bresp_q, bresp_d;
  logic [1:0]         rresp_q, rresp_d;

  logic aw_hs, w_hs, ar_hs;
  logic wr_pick;
  logic lio_done, lio_fail, lio_zero;

  // Protection bits carry no meaning on the LIO side.
  logic unused_prot;
  assign unused_prot = ^{awprot, arprot};

  // ---------------------------------------------------------------------------
  // Transfer completion: a real ack, or (optionally) the ack timeout.
  // ---------------------------------------------------------------------------
`ifdef AXIL_LIO_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             timeout;

  // The counter is 0 in the first request cycle, so the request stays up for
  // exactly TIMEOUT_CYCLES cycles. A real ack in the final cycle still wins.
  assign timeout  = lio_req && !lio_ack && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign lio_done = lio_ack || timeout;
  assign lio_fail = lio_err || timeout;
  assign lio_zero = timeout;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else if (lio_req) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= '0;
    end
  end
`else
  assign lio_done = lio_ack;
  assign lio_fail = lio_err;
  assign lio_zero = 1'b0;

  // TIMEOUT_CYCLES has no effect without the timeout feature.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  // ---------------------------------------------------------------------------
  // Channel readies. active_q keeps every ready low during reset and for the
  // first edge after it, so no handshake can complete against a reset state.
  // ---------------------------------------------------------------------------
  // A pending write is selected unless a read is also pending and the previous
  // arbitration went to a write (round-robin).
  assign wr_pick = (awvalid || wvalid) && !(arvalid && last_was_wr_q);

  // NOTE: every output of a combinational block is given a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    arready = 1'b0;
    if (active_q) begin
      case (state_q)
        IDLE: begin
          awready = !(arvalid && last_was_wr_q);
          wready  = !(arvalid && last_was_wr_q);
          arready = !wr_pick;
        end
        WR_COLLECT: begin
          awready = !aw_have_q;
          wready  = !w_have_q;
        end
        default: ;
      endcase
    end
  end

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid  && wready;
  assign ar_hs = arvalid && arready;

  // ---------------------------------------------------------------------------
  // Next-state and datapath capture
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    last_was_wr_d = last_was_wr_q;
    aw_have_d     = aw_have_q;
    w_have_d      = w_have_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rdata_d       = rdata_q;
    bresp_d       = bresp_q;
    rresp_d       = rresp_q;

    // AW and W land straight in the LIO payload registers; lio_req is low
    // until both have arrived, so the payload may still change meanwhile.
    if (aw_hs) begin
      addr_d    = awaddr;
      aw_have_d = 1'b1;
    end
    if (w_hs) begin
      wdata_d  = wdata;
      wstrb_d  = wstrb;
      w_have_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (aw_hs || w_hs) begin
          last_was_wr_d = 1'b1;
          state_d       = (aw_hs && w_hs) ? LIO_WR : WR_COLLECT;
        end else if (ar_hs) begin
          addr_d        = araddr;
          last_was_wr_d = 1'b0;
          state_d       = LIO_RD;
        end
      end
      WR_COLLECT: begin
        if ((aw_have_q || aw_hs) && (w_have_q || w_hs)) begin
          state_d = LIO_WR;
        end
      end
      LIO_WR: begin
        if (lio_done) begin
          bresp_d = lio_resp(lio_fail);
          state_d = WR_RESP;
        end
      end
      LIO_RD: begin
        if (lio_done) begin
          rdata_d = lio_zero ? '0 : lio_rdata;
          rresp_d = lio_resp(lio_fail);
          state_d = RD_RESP;
        end
      end
      WR_RESP: begin
        if (bready) begin
          state_d = IDLE;
        end
      end
      RD_RESP: begin
        if (rready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Both halves of the write are consumed once the LIO write is launched.
    if (state_d == LIO_WR) begin
      aw_have_d = 1'b0;
      w_have_d  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      active_q      <= 1'b0;
      last_was_wr_q <= 1'b0;
      aw_have_q     <= 1'b0;
      w_have_q      <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rdata_q       <= '0;
      bresp_q       <= AXI_RESP_OKAY;
      rresp_q       <= AXI_RESP_OKAY;
    end else begin
      state_q       <= state_d;
      active_q      <= 1'b1;
      last_was_wr_q <= last_was_wr_d;
      aw_have_q     <= aw_have_d;
      w_have_q      <= w_have_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rdata_q       <= rdata_d;
      bresp_q       <= bresp_d;
      rresp_q       <= rresp_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: handshake strobes decode straight from the registered state.
  // ---------------------------------------------------------------------------
  assign lio_req   = (state_q == LIO_WR) || (state_q == LIO_RD);
  assign lio_we    = (state_q == LIO_WR);
  assign lio_addr  = addr_q;
  assign lio_wdata = wdata_q;
  assign lio_wstrb = wstrb_q;
  assign bvalid    = (state_q == WR_RESP);
  assign bresp     = bresp_q;
  assign rvalid    = (state_q == RD_RESP);
  assign rdata     = rdata_q;
  assign rresp     = rresp_q;

endmodule
